// File: rtl/idma_sync_256b_pkg.sv
// Shared constants and FSM type for the 256-bit sync iDMA address generators.
package idma_sync_256b_pkg;

  localparam int unsigned AXI_BEAT_BYTES = 32;
  localparam logic [2:0]  AXI_SIZE_256B  = 3'd5;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned AXI_MAX_BURST  = 16;
  localparam int unsigned BEATS_PER_4K   = 128;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StIssue,
    StWaitResp
  } addr_gen_state_e;

endpackage

// File: rtl/idma_sync_256b_burst_calc.sv
// Burst sizing: beats = min(16, remaining beats, beats left in the current 4 KB page).
module idma_sync_256b_burst_calc
  import idma_sync_256b_pkg::*;
#(
  parameter int unsigned RemW = 16
) (
  input  logic [6:0]      page_beat_i,
  input  logic [RemW-1:0] rem_beats_i,
  output logic [4:0]      beats_o,
  output logic [3:0]      awlen_o,
  output logic            last_o
);

  logic [7:0] to_4k;
  logic [4:0] lim;

  always_comb begin
    to_4k   = 8'(BEATS_PER_4K) - {1'b0, page_beat_i};
    lim     = (to_4k < 8'(AXI_MAX_BURST)) ? to_4k[4:0] : 5'(AXI_MAX_BURST);
    beats_o = (rem_beats_i < RemW'(lim)) ? rem_beats_i[4:0] : lim;
    awlen_o = 4'(beats_o - 5'd1);
    last_o  = (RemW'(beats_o) == rem_beats_i);
  end

endmodule

// File: rtl/idma_sync_256b_waddr_gen.sv
// AXI AW generator: splits one write descriptor into 4 KB-safe INCR bursts and tracks B responses.
module idma_sync_256b_waddr_gen
  import idma_sync_256b_pkg::*;
#(
  parameter int unsigned AXI_IDW      = 4,
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned LEN_WID      = 20,
  parameter int unsigned MAX_OUTSTD   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    wr_cfg_init,
  input  logic [AXI_ADDR_WID-1:0] cfg_addr,
  input  logic [LEN_WID-1:0]      cfg_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    wlen_fifo_full_s,
  output logic [3:0]              wlen_fifo_data_s,
  output logic                    wlen_fifo_push,
  output logic                    axi_burst_waddr_ok,
  input  logic                    axi_burst_wdata_ok,
  output logic                    o_awvalid,
  output logic [AXI_ADDR_WID-1:0] o_awaddr,
  output logic [3:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic [AXI_IDW-1:0]      o_awid,
  input  logic                    i_awready,
  output logic [5:0]              strb_first_beat_num,
  output logic [5:0]              strb_last_beat_num,
  output logic                    dma_trans_first_burst,
  output logic                    dma_trans_last_burst
);

  localparam int unsigned RemW = LEN_WID - 4;
  localparam int unsigned OutW = $clog2(MAX_OUTSTD + 1);

  addr_gen_state_e state_q, state_d;

  logic [AXI_ADDR_WID-1:0] addr_q, addr_d;
  logic [RemW-1:0]         rem_q, rem_d;
  logic [4:0]              beats_q, beats_d;
  logic [3:0]              awlen_q, awlen_d;
  logic                    last_q, last_d;
  logic                    first_q, first_d;
  logic                    awv_hold_q, awv_hold_d;
  logic [OutW-1:0]         outstd_q, outstd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [5:0]              sfirst_q, sfirst_d;
  logic [5:0]              slast_q, slast_d;

  logic [4:0]         offs;
  logic [LEN_WID:0]   span;
  logic [RemW-1:0]    tot_beats;
  logic [5:0]         first_room;
  logic [5:0]         sfirst_calc;
  logic [5:0]         slast_calc;
  logic [RemW-1:0]    rem_after;
  logic [4:0]         calc_beats;
  logic [3:0]         calc_awlen;
  logic               calc_last;
  logic               aw_hs;

  idma_sync_256b_burst_calc #(
    .RemW (RemW)
  ) u_burst_calc (
    .page_beat_i (addr_q[11:5]),
    .rem_beats_i (rem_q),
    .beats_o     (calc_beats),
    .awlen_o     (calc_awlen),
    .last_o      (calc_last)
  );

  // Descriptor geometry, evaluated directly from the cfg inputs.
  always_comb begin
    offs        = cfg_addr[4:0];
    span        = (LEN_WID+1)'(cfg_len) + (LEN_WID+1)'(offs);
    tot_beats   = RemW'((span + (LEN_WID+1)'(31)) >> 5);
    first_room  = 6'd32 - {1'b0, offs};
    sfirst_calc = (cfg_len < LEN_WID'(first_room)) ? cfg_len[5:0] : first_room;
    slast_calc  = (tot_beats == RemW'(1)) ? sfirst_calc : {1'b0, 5'(span - 1'b1)} + 6'd1;
  end

  assign rem_after = rem_q - RemW'(beats_q);
  assign aw_hs     = o_awvalid & i_awready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (wr_cfg_init && (cfg_len != '0)) state_d = StCalc;
      StCalc:     state_d = StIssue;
      StIssue:    if (aw_hs) state_d = (rem_after != '0) ? StCalc : StWaitResp;
      StWaitResp: if (outstd_d == '0) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // A response with nothing outstanding is dropped; a response coinciding with an AW cancels it.
  always_comb begin
    outstd_d = outstd_q;
    if (aw_hs && !axi_burst_wdata_ok) begin
      outstd_d = outstd_q + 1'b1;
    end else if (!aw_hs && axi_burst_wdata_ok && (outstd_q != '0)) begin
      outstd_d = outstd_q - 1'b1;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    awlen_d    = awlen_q;
    last_d     = last_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sfirst_d   = sfirst_q;
    slast_d    = slast_q;
    awv_hold_d = o_awvalid & ~i_awready;
    unique case (state_q)
      StIdle: begin
        if (wr_cfg_init) begin
          addr_d  = {cfg_addr[AXI_ADDR_WID-1:5], 5'b0};
          rem_d   = tot_beats;
          first_d = 1'b1;
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            sfirst_d = sfirst_calc;
            slast_d  = slast_calc;
          end
        end
      end
      StCalc: begin
        beats_d = calc_beats;
        awlen_d = calc_awlen;
        last_d  = calc_last;
      end
      StIssue: begin
        if (aw_hs) begin
          addr_d  = addr_q + (AXI_ADDR_WID'(beats_q) << 5);
          rem_d   = rem_after;
          first_d = 1'b0;
        end
      end
      StWaitResp: begin
        if (outstd_d == '0) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      awlen_q    <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
      awv_hold_q <= 1'b0;
      outstd_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sfirst_q   <= '0;
      slast_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      awlen_q    <= awlen_d;
      last_q     <= last_d;
      first_q    <= first_d;
      awv_hold_q <= awv_hold_d;
      outstd_q   <= outstd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sfirst_q   <= sfirst_d;
      slast_q    <= slast_d;
    end
  end

  // Once raised, AWVALID is held by awv_hold_q regardless of FIFO/outstanding gating.
  always_comb begin
    o_awvalid             = (state_q == StIssue) &&
                            (awv_hold_q || (!wlen_fifo_full_s && (outstd_q < OutW'(MAX_OUTSTD))));
    o_awaddr              = addr_q;
    o_awlen               = awlen_q;
    o_awsize              = AXI_SIZE_256B;
    o_awburst             = AXI_BURST_INCR;
    o_awid                = '0;
    wlen_fifo_push        = aw_hs;
    axi_burst_waddr_ok    = aw_hs;
    wlen_fifo_data_s      = awlen_q;
    busy                  = busy_q;
    done                  = done_q;
    strb_first_beat_num   = sfirst_q;
    strb_last_beat_num    = slast_q;
    dma_trans_first_burst = first_q & (state_q == StIssue);
    dma_trans_last_burst  = last_q & (state_q == StIssue);
  end

endmodule

// File: doc/idma_sync_256b_waddr_gen.md
Name: idma_sync_256b_waddr_gen

Overview:
- AXI write-address stage of the 256-bit sync iDMA; sits directly upstream of the write-data processor.
- Takes one write descriptor (start byte address, byte length) and splits it into INCR bursts that are at most 16 beats and never cross a 4 KB boundary.
- Drives the AW channel and pushes each burst's AWLEN into the write-data processor's wlen FIFO.
- Supplies first/last-beat byte counts and first/last-burst flags, tracks outstanding bursts via write-response completions, and pulses done when all responses have returned.

Parameters:
- AXI_IDW, 4, AXI ID width.
- AXI_ADDR_WID, 32, address width.
- LEN_WID, 20, descriptor byte-length width.
- MAX_OUTSTD, 4, maximum issued bursts without a response; must be ≤ wlen FIFO depth (8).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- wr_cfg_init  in  1  start pulse; captures cfg_* in IDLE
- cfg_addr  in  AXI_ADDR_WID  start byte address, any alignment
- cfg_len  in  LEN_WID  byte count; 0 is legal
- busy  out  1  descriptor in progress
- done  out  1  one-cycle pulse when complete
- wlen_fifo_full_s  in  1  wlen FIFO full
- wlen_fifo_data_s  out  4  AWLEN of the issued burst
- wlen_fifo_push  out  1  push, equal to the AW handshake
- axi_burst_waddr_ok  out  1  AW handshake pulse
- axi_burst_wdata_ok  in  1  one burst's OKAY B response
- o_awvalid  out  1  AW valid
- o_awaddr  out  AXI_ADDR_WID  burst address, 32 B aligned
- o_awlen  out  4  beats-1
- o_awsize  out  3  constant 3'd5
- o_awburst  out  2  constant 2'b01
- o_awid  out  AXI_IDW  constant 0
- i_awready  in  1  AW ready
- strb_first_beat_num  out  6  valid bytes in the descriptor's first beat, 1..32
- strb_last_beat_num  out  6  valid bytes in the last beat, 1..32
- dma_trans_first_burst  out  1  current AW burst is the first
- dma_trans_last_burst  out  1  current AW burst is the last

Behaviour:
- Reset: every output is 0 except o_awsize=5 and o_awburst=1; FSM in IDLE; all counters 0.
- Reset asserted mid-operation abandons the descriptor immediately; no done pulse is produced.
- FSM states: IDLE, CALC, ISSUE, WAIT_RESP.
- IDLE:
  - On wr_cfg_init, capture the address aligned down to 32 B.
  - Compute `offs = addr[4:0]`.
  - Compute `tot_beats = (offs + cfg_len + 31) >> 5`, held at LEN_WID-4 bits.
  - Compute `strb_first_beat_num = min(32 - offs, cfg_len)`.
  - Compute `strb_last_beat_num = ((offs + cfg_len - 1) & 31) + 1`; it equals `strb_first_beat_num` when `tot_beats == 1`.
  - If cfg_len is 0, pulse done on the next cycle and stay in IDLE.
  - Otherwise set busy and go to CALC.
  - wr_cfg_init while busy is ignored.
- CALC (1 cycle):
  - `beats = min(16, rem_beats, 128 - addr[11:5])`.
  - Register `o_awlen = beats - 1`, then go to ISSUE.
- ISSUE:
  - o_awvalid is asserted only when `!wlen_fifo_full_s` and `outstd < MAX_OUTSTD`.
  - Once asserted, o_awvalid and the AW payload hold until i_awready.
  - On handshake:
    - wlen_fifo_push = axi_burst_waddr_ok = 1 for one cycle, with wlen_fifo_data_s = o_awlen.
    - Advance the address by beats×32 and decrement rem_beats by beats.
    - Increment outstd, unless axi_burst_wdata_ok occurs in the same cycle, in which case outstd is unchanged.
  - Next state: CALC if rem_beats remains, else WAIT_RESP.
  - dma_trans_first_burst is high for the first burst's AW.
  - dma_trans_last_burst is high when `beats == rem_beats`.
  - Both flags are stable while o_awvalid is high.
- WAIT_RESP:
  - Decrement outstd on each axi_burst_wdata_ok.
  - When outstd reaches 0, pulse done, clear busy, go to IDLE.
  - A response arriving in the same cycle as entry is counted.
- outstd:
  - Decrements on axi_burst_wdata_ok in any state.
  - A response while outstd = 0 is ignored; outstd saturates at 0.
- Address wrap past 2^AXI_ADDR_WID wraps silently.

Decomposition:
- Shared package idma_sync_256b_pkg:
  - Constants AXI_BEAT_BYTES=32, AXI_SIZE_256B=3'd5, AXI_BURST_INCR=2'b01, AXI_MAX_BURST=16, BEATS_PER_4K=128.
  - FSM enum type.
- One natural sub-module, idma_sync_256b_burst_calc: combinational beats/AWLEN computation from address and remaining beats, reusable by the read-address generator.

Test Plan:
- addr=0x1000, len=1024 → 2 bursts AWLEN=15 at 0x1000 and 0x1200; first_burst on #1, last_burst on #2; strb_first=32, strb_last=32; done after 2 wdata_ok.
- addr=0x0FE5, len=100:
  - offs=5, tot_beats=4, beats to 4 KB boundary=1.
  - Bursts: AWLEN=0 at 0x0FE0, then AWLEN=2 at 0x1000.
  - strb_first=27, strb_last=9.
- addr=0x2003, len=10 → single burst AWLEN=0; strb_first=strb_last=10; first and last flags both high.
- len=0 → no AW; done pulses one cycle after wr_cfg_init; busy stays 0.
- len=4096, aligned, MAX_OUTSTD=4, no responses → exactly 4 AWs issued, then stall; each wdata_ok releases one AW; done after the 8th response.
- Hold i_awready low 5 cycles and toggle wlen_fifo_full_s → payload stable while o_awvalid is high; a new o_awvalid never rises while the FIFO is full; reset mid-burst returns all outputs to reset values.
